dpwm_capture: RTL and testbench

- Measures a PWM waveform, the receiving end of the DPWM/divider output chain.
- Samples an asynchronous PWM_IN in the CLK_IN domain and measures period and high time in CLK_IN cycles.
- Publishes each completed rising-to-rising measurement with a one-cycle VALID strobe.
- Used for closed-loop duty verification and for self-test of the frequency divider and DPWM outputs.

---
 rtl/dpwm_capture.sv | 172 +++++++++++++++++
 tb/tb_dpwm_capture.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpwm_capture.sv
// PWM capture: synchronizes PWM_IN into CLK_IN and measures period and high time.
// Optional glitch filter in front of the edge detector: define DPWM_CAP_GLITCH_FILT_EN.
module dpwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             CLK_IN,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             PWM_IN,
    input  logic             CLR_OVF,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_TIME,
    output logic             VALID,
    output logic             OVF
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (FILT_LEN < 1) begin : g_bad_filt
        $error("FILT_LEN must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   lvl;
    logic                   lvl_d;
    logic                   rise;
    logic                   fall;

    // NOTE: every flop uses non-blocking assignment so all registers update from pre-edge values.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], PWM_IN};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef DPWM_CAP_GLITCH_FILT_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);

    logic [FC_W-1:0] filt_cnt;

    // Level follows s only once s has disagreed for FILT_LEN consecutive cycles.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            lvl      <= 1'b0;
            filt_cnt <= '0;
        end else if (s == lvl) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
            lvl      <= s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end
`else
    assign lvl = s;
`endif

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] period_d, high_d;
    logic             valid_d;
    logic             ovf_set;
    logic             ovf_d;

    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        period_d = PERIOD;
        high_d   = HIGH_TIME;
        valid_d  = 1'b0;
        ovf_set  = 1'b0;

        if (!EN) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d   = '0;
                    state_d = S_ARM;
                end
                S_ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = S_HIGH;
                    end
                end
                S_HIGH: begin
                    // A fall at full count leaves no room to count the low phase either.
                    if (cnt_q == CNT_MAX) begin
                        ovf_set = 1'b1;
                        cnt_d   = '0;
                        state_d = S_ARM;
                    end else if (fall) begin
                        hi_d    = cnt_q;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_LOW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hi_q;
                        valid_d  = 1'b1;
                        cnt_d    = CNT_ONE;
                        state_d  = S_HIGH;
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_set = 1'b1;
                        cnt_d   = '0;
                        state_d = S_ARM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        ovf_d = ovf_set | (OVF & ~CLR_OVF);
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            PERIOD    <= '0;
            HIGH_TIME <= '0;
            VALID     <= 1'b0;
            OVF       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            PERIOD    <= period_d;
            HIGH_TIME <= high_d;
            VALID     <= valid_d;
            OVF       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_dpwm_capture.sv
// Self-checking bench for dpwm_capture: segment-based PWM stimulus scored against a
// run-length model of the waveform; honours DPWM_CAP_GLITCH_FILT_EN when defined.
module tb_dpwm_capture;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 4;
`ifdef DPWM_CAP_GLITCH_FILT_EN
    localparam int FILT_DLY  = FILT_LEN;
    localparam int MIN_PULSE = FILT_LEN;
`else
    localparam int FILT_DLY  = 0;
    localparam int MIN_PULSE = 1;
`endif
    localparam int LAT  = SYNC_STAGES + 1 + FILT_DLY;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             CLK_IN  = 1'b0;
    logic             RST_N   = 1'b0;
    logic             EN      = 1'b0;
    logic             PWM_IN  = 1'b0;
    logic             CLR_OVF = 1'b0;
    logic [CNT_W-1:0] PERIOD;
    logic [CNT_W-1:0] HIGH_TIME;
    logic             VALID;
    logic             OVF;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int got_p[$], got_h[$], got_c[$];
    bit seg_lvl[$];
    int seg_len[$];
    int exp_p[$], exp_h[$];
    int last_p = 0;
    int last_h = 0;

    dpwm_capture #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) dut (
        .CLK_IN   (CLK_IN),
        .RST_N    (RST_N),
        .EN       (EN),
        .PWM_IN   (PWM_IN),
        .CLR_OVF  (CLR_OVF),
        .PERIOD   (PERIOD),
        .HIGH_TIME(HIGH_TIME),
        .VALID    (VALID),
        .OVF      (OVF)
    );

    always #5 CLK_IN = ~CLK_IN;

    always @(posedge CLK_IN) cyc <= cyc + 1;

    always @(negedge CLK_IN) begin
        if (VALID === 1'b1) begin
            got_p.push_back(int'(PERIOD));
            got_h.push_back(int'(HIGH_TIME));
            got_c.push_back(cyc);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_segs();
        seg_lvl.delete();
        seg_len.delete();
    endtask

    task automatic add_seg(input bit lvl, input int len);
        seg_lvl.push_back(lvl);
        seg_len.push_back(len);
    endtask

    // Reference: expand segments to one level per clock, optionally filter, then every
    // pair of consecutive rises yields (rise-to-rise distance, rise-to-fall distance).
    function automatic void build_expected(input bit init_lvl);
        bit lv[$];
        bit prev;
        int rise_at;
        int fall_at;
`ifdef DPWM_CAP_GLITCH_FILT_EN
        bit flt;
        int run;
`endif
        exp_p.delete();
        exp_h.delete();
        foreach (seg_lvl[k]) begin
            for (int j = 0; j < seg_len[k]; j++) lv.push_back(seg_lvl[k]);
        end
`ifdef DPWM_CAP_GLITCH_FILT_EN
        flt = init_lvl;
        run = 0;
        foreach (lv[i]) begin
            if (lv[i] != flt) begin
                run++;
                if (run == FILT_LEN) begin
                    flt = lv[i];
                    run = 0;
                end
            end else begin
                run = 0;
            end
            lv[i] = flt;
        end
`endif
        prev    = init_lvl;
        rise_at = -1;
        fall_at = -1;
        foreach (lv[i]) begin
            if (lv[i] && !prev) begin
                if (rise_at >= 0) begin
                    exp_p.push_back(i - rise_at);
                    exp_h.push_back(fall_at - rise_at);
                end
                rise_at = i;
            end
            if (!lv[i] && prev) fall_at = i;
            prev = lv[i];
        end
    endfunction

    task automatic play();
        got_p.delete();
        got_h.delete();
        got_c.delete();
        foreach (seg_lvl[k]) begin
            PWM_IN = seg_lvl[k];
            repeat (seg_len[k]) @(negedge CLK_IN);
        end
        repeat (LAT + 3) @(negedge CLK_IN);
    endtask

    task automatic compare_expected(input string name);
        n_cmp++;
        if (got_p.size() !== exp_p.size()) begin
            n_bad++;
            $display("FAIL %s valid_count: got %0d expected %0d", name, got_p.size(), exp_p.size());
        end
        for (int i = 0; i < exp_p.size() && i < got_p.size(); i++) begin
            n_cmp++;
            if (got_p[i] !== exp_p[i]) begin
                n_bad++;
                $display("FAIL %s period[%0d]: got %0d expected %0d", name, i, got_p[i], exp_p[i]);
            end
            n_cmp++;
            if (got_h[i] !== exp_h[i]) begin
                n_bad++;
                $display("FAIL %s high[%0d]: got %0d expected %0d", name, i, got_h[i], exp_h[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (got_c[i] - got_c[i-1] !== exp_p[i]) begin
                    n_bad++;
                    $display("FAIL %s spacing[%0d]: got %0d expected %0d", name, i,
                             got_c[i] - got_c[i-1], exp_p[i]);
                end
            end
        end
        if (exp_p.size() > 0) begin
            last_p = exp_p[exp_p.size()-1];
            last_h = exp_h[exp_h.size()-1];
        end
    endtask

    task automatic quiesce();
        EN      = 1'b0;
        PWM_IN  = 1'b0;
        CLR_OVF = 1'b0;
        repeat (LAT + 8) @(negedge CLK_IN);
        EN = 1'b1;
        @(negedge CLK_IN);
    endtask

    task automatic check_outputs(input string name, input int ep, input int eh, input int eo);
        n_cmp++;
        if (PERIOD !== ep[CNT_W-1:0]) begin
            n_bad++;
            $display("FAIL %s PERIOD: got %0d expected %0d", name, PERIOD, ep);
        end
        n_cmp++;
        if (HIGH_TIME !== eh[CNT_W-1:0]) begin
            n_bad++;
            $display("FAIL %s HIGH_TIME: got %0d expected %0d", name, HIGH_TIME, eh);
        end
        n_cmp++;
        if (OVF !== eo[0]) begin
            n_bad++;
            $display("FAIL %s OVF: got %b expected %0d", name, OVF, eo);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK_IN);
        check_outputs("reset", 0, 0, 0);
        n_cmp++;
        if (VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL reset VALID: got %b expected 0", VALID);
        end
        RST_N = 1'b1;
        @(negedge CLK_IN);
    endtask

    task automatic test_basic();
        int start;
        quiesce();
        clear_segs();
        for (int k = 0; k < 4; k++) begin
            add_seg(1'b1, 30);
            add_seg(1'b0, 70);
        end
        add_seg(1'b1, 10);
        start = cyc;
        play();
        build_expected(1'b0);
        compare_expected("basic");
        n_cmp++;
        if (got_c.size() == 0 || got_c[0] !== start + 100 + LAT) begin
            n_bad++;
            $display("FAIL basic first_valid_cycle: got %0d expected %0d",
                     got_c.size() == 0 ? -1 : got_c[0], start + 100 + LAT);
        end
        check_outputs("basic", 100, 30, 0);
    endtask

    task automatic test_duty_change();
        quiesce();
        clear_segs();
        for (int k = 0; k < 2; k++) begin
            add_seg(1'b1, 30);
            add_seg(1'b0, 70);
        end
        for (int k = 0; k < 2; k++) begin
            add_seg(1'b1, 75);
            add_seg(1'b0, 25);
        end
        add_seg(1'b1, 10);
        play();
        build_expected(1'b0);
        compare_expected("duty_change");
        check_outputs("duty_change", 100, 75, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            quiesce();
            clear_segs();
            for (int k = 0; k < 8; k++) begin
                add_seg(1'b1, int'($urandom_range(110, MIN_PULSE)));
                add_seg(1'b0, int'($urandom_range(110, MIN_PULSE)));
            end
            add_seg(1'b1, MIN_PULSE + 2);
            play();
            build_expected(1'b0);
            compare_expected("random");
        end
    endtask

    task automatic test_glitch();
        quiesce();
        clear_segs();
        add_seg(1'b1, 10);
        add_seg(1'b0, 2);
        add_seg(1'b1, 18);
        add_seg(1'b0, 70);
        add_seg(1'b1, 30);
        add_seg(1'b0, 70);
        add_seg(1'b1, 10);
        play();
        build_expected(1'b0);
        compare_expected("glitch");
`ifdef DPWM_CAP_GLITCH_FILT_EN
        n_cmp++;
        if (got_p.size() < 1 || got_p[0] !== 100 || got_h[0] !== 30) begin
            n_bad++;
            $display("FAIL glitch_filtered first: got %0d/%0d expected 100/30",
                     got_p.size() < 1 ? -1 : got_p[0], got_h.size() < 1 ? -1 : got_h[0]);
        end
`else
        n_cmp++;
        if (got_p.size() < 2 || got_p[0] !== 12 || got_h[0] !== 10 ||
            got_p[1] !== 88 || got_h[1] !== 18) begin
            n_bad++;
            $display("FAIL glitch_raw first_two: got %0d/%0d %0d/%0d expected 12/10 88/18",
                     got_p.size() < 1 ? -1 : got_p[0], got_h.size() < 1 ? -1 : got_h[0],
                     got_p.size() < 2 ? -1 : got_p[1], got_h.size() < 2 ? -1 : got_h[1]);
        end
`endif
    endtask

    task automatic test_enable();
        int start;
        quiesce();
        clear_segs();
        add_seg(1'b1, 30);
        add_seg(1'b0, 70);
        add_seg(1'b1, 30);
        add_seg(1'b0, 20);
        play();
        build_expected(1'b0);
        compare_expected("enable_pre");
        // Disabled 50 cycles into a period; the waveform keeps running.
        EN = 1'b0;
        clear_segs();
        add_seg(1'b0, 30);
        add_seg(1'b1, 30);
        add_seg(1'b0, 70);
        add_seg(1'b1, 15);
        play();
        n_cmp++;
        if (got_p.size() !== 0) begin
            n_bad++;
            $display("FAIL enable_off valid_count: got %0d expected 0", got_p.size());
        end
        check_outputs("enable_off", 100, 30, 0);
        // Re-enabled in the middle of a high phase.
        EN = 1'b1;
        clear_segs();
        add_seg(1'b1, 15);
        add_seg(1'b0, 60);
        add_seg(1'b1, 45);
        add_seg(1'b0, 55);
        add_seg(1'b1, 45);
        add_seg(1'b0, 55);
        add_seg(1'b1, 5);
        start = cyc;
        play();
        build_expected(1'b1);
        compare_expected("enable_on");
        n_cmp++;
        if (got_c.size() == 0 || got_c[0] !== start + 175 + LAT) begin
            n_bad++;
            $display("FAIL enable_on first_valid_cycle: got %0d expected %0d",
                     got_c.size() == 0 ? -1 : got_c[0], start + 175 + LAT);
        end
    endtask

    task automatic wait_ovf(input string name, input int m);
        int t;
        t = -1;
        for (int k = 0; k < CMAX + LAT + 20; k++) begin
            @(negedge CLK_IN);
            if (OVF === 1'b1) begin
                t = cyc;
                break;
            end
        end
        n_cmp++;
        if (t !== m + LAT + CMAX) begin
            n_bad++;
            $display("FAIL %s ovf_cycle: got %0d expected %0d", name, t, m + LAT + CMAX);
        end
        n_cmp++;
        if (got_p.size() !== 0) begin
            n_bad++;
            $display("FAIL %s valid_count: got %0d expected 0", name, got_p.size());
        end
        check_outputs(name, last_p, last_h, 1);
    endtask

    task automatic pulse_clr(input string name, input int eo);
        CLR_OVF = 1'b1;
        @(negedge CLK_IN);
        CLR_OVF = 1'b0;
        n_cmp++;
        if (OVF !== eo[0]) begin
            n_bad++;
            $display("FAIL %s OVF: got %b expected %0d", name, OVF, eo);
        end
    endtask

    task automatic test_overflow();
        int m;
        quiesce();
        got_p.delete();
        got_h.delete();
        got_c.delete();
        // Stuck high after one rise.
        m = cyc;
        PWM_IN = 1'b1;
        wait_ovf("ovf_high", m);
        pulse_clr("ovf_clear", 0);
        // Clear request on the same edge as a fresh overflow.
        PWM_IN = 1'b0;
        repeat (LAT + 4) @(negedge CLK_IN);
        m = cyc;
        PWM_IN = 1'b1;
        repeat (LAT + CMAX - 1) @(negedge CLK_IN);
        n_cmp++;
        if (OVF !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_pre_coincide OVF: got %b expected 0", OVF);
        end
        pulse_clr("ovf_set_wins", 1);
        pulse_clr("ovf_clear2", 0);
        // Stuck low after a short high phase.
        PWM_IN = 1'b0;
        repeat (LAT + 4) @(negedge CLK_IN);
        m = cyc;
        PWM_IN = 1'b1;
        repeat (5) @(negedge CLK_IN);
        PWM_IN = 1'b0;
        wait_ovf("ovf_low", m - 5 + 5);
        pulse_clr("ovf_clear3", 0);
    endtask

    task automatic test_async_reset();
        quiesce();
        clear_segs();
        add_seg(1'b1, 30);
        add_seg(1'b0, 70);
        add_seg(1'b1, 30);
        add_seg(1'b0, 70);
        add_seg(1'b1, 10);
        play();
        build_expected(1'b0);
        compare_expected("async_pre");
        #2;
        RST_N = 1'b0;
        #1;
        check_outputs("async_reset", 0, 0, 0);
        @(negedge CLK_IN);
        RST_N = 1'b1;
        last_p = 0;
        last_h = 0;
        quiesce();
        clear_segs();
        add_seg(1'b1, 40);
        add_seg(1'b0, 60);
        add_seg(1'b1, 10);
        play();
        build_expected(1'b0);
        compare_expected("async_recover");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_change();
        test_random();
        test_glitch();
        test_enable();
        test_overflow();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
